// File: rtl/cnt_call_pkg.sv
// Shared definitions for the counter-call scheduler.
// Contents: default sizing constants, FSM state encoding, index-width helper.
package cnt_call_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned CW_DEF   = 32;

    // FSM state encoding, kept as plain localparams for legacy tool flows.
    typedef logic [1:0] state_t;
    localparam state_t StIdle = 2'd0;
    localparam state_t StCall = 2'd1;
    localparam state_t StRet  = 2'd2;

    // Width of a requester index; never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester selection.
// Ports:
//   req - request vector (NREQ bits)
//   ptr - index where the search starts; searches upward and wraps
//   sel - one-hot of the chosen requester (0 when req == 0)
//   idx - binary index of the chosen requester (0 when req == 0)
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] sel,
    output logic [IW-1:0]   idx
);

    // (p + k) mod NREQ, valid because p < NREQ and k < NREQ.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int unsigned k);
        int unsigned s;
        s = {{(32-IW){1'b0}}, p} + k;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return s[IW-1:0];
    endfunction

    logic          found;
    logic [IW-1:0] pos;

    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = wrap_add(ptr, k);
            if (!found && req[pos]) begin
                found    = 1'b1;
                idx      = pos;
                sel[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnt_call_sched.sv
// Counter-call scheduler: arbitrates NREQ requesters round-robin and serves one
// "call" at a time through an IDLE -> CALL -> RET sequence. A static call
// increments a shared accumulating counter; an automatic call always yields 1.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   req        - per-requester level request, held until its response
//   auto_mode  - 1 = automatic call, 0 = static call (sampled at call start)
//   clr        - synchronous clear of the static counter
//   gnt        - registered one-hot grant, non-zero only in CALL and RET
//   rsp_valid  - one-cycle response pulse (during RET)
//   rsp_id     - index of the requester the response belongs to
//   rsp_cnt    - call result
//   busy       - FSM not in IDLE
module cnt_call_sched
    import cnt_call_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned CW   = CW_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic                     auto_mode,
    input  logic                     clr,
    output logic [NREQ-1:0]          gnt,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [CW-1:0]            rsp_cnt,
    output logic                     busy
);

    localparam int unsigned IW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   id_q, id_d;
    logic            auto_q, auto_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]   rsp_id_q, rsp_id_d;
    logic [CW-1:0]   rsp_cnt_q, rsp_cnt_d;

    logic [NREQ-1:0] pick_sel;
    logic [IW-1:0]   pick_idx;
    logic [CW-1:0]   base;
    logic [CW-1:0]   result;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .sel (pick_sel),
        .idx (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        id_d        = id_q;
        auto_d      = auto_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_cnt_d   = rsp_cnt_q;
        result      = '0;

        // clr acts every cycle; a static CALL in the same cycle counts up from 0.
        base  = clr ? '0 : cnt_q;
        cnt_d = base;

        case (state_q)
            StCall: begin
                state_d = StRet;
                if (auto_q) begin
                    result = CW'(1);
                end else begin
                    result = base + CW'(1);
                    cnt_d  = result;
                end
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_cnt_d   = result;
            end
            StRet: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
            default: begin
                gnt_d = '0;
                if (|req) begin
                    state_d = StCall;
                    gnt_d   = pick_sel;
                    id_d    = pick_idx;
                    ptr_d   = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
                    auto_d  = auto_mode;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            id_q        <= '0;
            auto_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            id_q        <= id_d;
            auto_q      <= auto_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_cnt_q   <= rsp_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_cnt   = rsp_cnt_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_cnt_call_sched.sv
// Directed testbench for cnt_call_sched.
// dut  : default sizing (NREQ=4, CW=32)
// dut4 : NREQ=4, CW=4 for counter wrap
module tb_cnt_call_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req4;
    logic        auto_mode, auto4, clr, clr4;

    logic [3:0]  gnt, gnt4;
    logic        rsp_valid, rv4;
    logic [1:0]  rsp_id, id4;
    logic [31:0] rsp_cnt;
    logic [3:0]  cnt4;
    logic        busy, busy4;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int cyc    = 0;
    int t0, t1;

    cnt_call_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .auto_mode (auto_mode),
        .clr       (clr),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_cnt   (rsp_cnt),
        .busy      (busy)
    );

    cnt_call_sched #(
        .NREQ (4),
        .CW   (4)
    ) dut4 (
        .clk       (clk),
        .rst       (rst),
        .req       (req4),
        .auto_mode (auto4),
        .clr       (clr4),
        .gnt       (gnt4),
        .rsp_valid (rv4),
        .rsp_id    (id4),
        .rsp_cnt   (cnt4),
        .busy      (busy4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Step negedge by negedge until a response appears (bounded), then check it.
    task automatic wait_rsp(input bit w4, input string tag, input int exp_id, input int exp_cnt,
                            output int at);
        int   n = 0;
        logic v;
        do begin
            @(negedge clk);
            n++;
            v = w4 ? rv4 : rsp_valid;
        end while (!v && n < 8);
        at = cyc;
        chk({tag, "_valid"}, v, 1);
        chk({tag, "_id"}, w4 ? id4 : rsp_id, exp_id);
        chk({tag, "_cnt"}, w4 ? {28'd0, cnt4} : rsp_cnt, exp_cnt);
        chk({tag, "_gnt"}, w4 ? gnt4 : gnt, 64'd1 << exp_id);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req = '0; req4 = '0;
        auto_mode = 1'b0; auto4 = 1'b0; clr = 1'b0; clr4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_cnt", rsp_cnt, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Static accumulation with 3-cycle spacing
        req = 4'b0001;
        wait_rsp(0, "st1", 0, 1, t0);
        wait_rsp(0, "st2", 0, 2, t1);
        chk("st_gap1", t1 - t0, 3);
        wait_rsp(0, "st3", 0, 3, t0);
        chk("st_gap2", t0 - t1, 3);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        chk("hold_cnt", rsp_cnt, 3);
        chk("hold_valid", rsp_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_gnt", gnt, 0);

        // Automatic calls leave the static counter alone
        do_reset();
        auto_mode = 1'b1;
        req = 4'b0001;
        wait_rsp(0, "au1", 0, 1, t0);
        wait_rsp(0, "au2", 0, 1, t0);
        wait_rsp(0, "au3", 0, 1, t0);
        auto_mode = 1'b0;
        wait_rsp(0, "au_st", 0, 1, t0);
        req = '0;
        // auto_mode flipped mid-call must not affect the call in flight
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        auto_mode = 1'b1;
        wait_rsp(0, "mode_hold", 0, 2, t0);
        req = '0;
        auto_mode = 1'b0;

        // Round-robin with all requesters active from reset
        @(negedge clk);
        rst = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_rsp(0, $sformatf("rr%0d", i), i % 4, i + 1, t0);
        end
        req = '0;

        // clr colliding with a static CALL
        req = 4'b0001;
        wait_rsp(0, "pre6", 0, 6, t0);
        wait_rsp(0, "pre7", 0, 7, t0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        wait_rsp(0, "clr_call", 0, 1, t0);
        clr = 1'b0;
        wait_rsp(0, "clr_next", 0, 2, t0);
        req = '0;

        // clr while idle
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        req = 4'b0001;
        wait_rsp(0, "clr_idle", 0, 1, t0);
        req = '0;

        // Reset during CALL; pointer is 1 so 4'b1001 first picks requester 3
        @(negedge clk);
        req = 4'b1001;
        @(negedge clk);
        chk("mid_gnt", gnt, 4'b1000);
        chk("mid_busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_gnt", gnt, 0);
        chk("mr_valid", rsp_valid, 0);
        @(negedge clk);
        chk("mr_valid2", rsp_valid, 0);
        rst = 1'b0;
        wait_rsp(0, "post_rst", 0, 1, t0);
        req = '0;

        // 4-bit counter wrap
        req4 = 4'b0001;
        for (int i = 1; i <= 17; i++) begin
            wait_rsp(1, $sformatf("wrap%0d", i), 0, i % 16, t0);
        end
        req4 = '0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
